// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor slice.
//   BP_IDX_WIDTH / BP_TAG_WIDTH : default BHT/BTB index and BTB tag widths
//   bht_state_e                 : 2-bit saturating direction counter states
package branch_predictor_pkg;

   localparam int BP_IDX_WIDTH = 6;
   localparam int BP_TAG_WIDTH = 8;

   typedef enum logic [1:0] {
      BHT_SNT = 2'b00,   // strongly not-taken
      BHT_WNT = 2'b01,   // weakly not-taken
      BHT_WT  = 2'b10,   // weakly taken
      BHT_ST  = 2'b11    // strongly taken
   } bht_state_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup / EX-feedback / redirect bundle between the core and the predictor.
//   master : core side (drives fetch PC and EX resolution, consumes prediction/flush/stats)
//   slave  : predictor side
interface branch_predictor_if;
   // fetch lookup
   logic [31:0] if_pc;
   logic        predict_taken;
   logic [31:0] predict_pc;
   // EX resolution feedback
   logic        ex_valid;
   logic        old_branch;
   logic        old_predict;
   logic        branch_result;
   logic [31:0] old_pc;
   logic [31:0] ex_target;
   // mispredict recovery
   logic        flush;
   logic [31:0] redirect_pc;
   // performance counters
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;

   modport master (
      output if_pc, ex_valid, old_branch, old_predict, branch_result, old_pc, ex_target,
      input  predict_taken, predict_pc, flush, redirect_pc, stat_branches, stat_mispred
   );

   modport slave (
      input  if_pc, ex_valid, old_branch, old_predict, branch_result, old_pc, ex_target,
      output predict_taken, predict_pc, flush, redirect_pc, stat_branches, stat_mispred
   );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state function.
//   state      : current counter value
//   taken      : resolved direction (1 = count up)
//   next_state : counter after training, clamped at 00 / 11
module branch_predictor_sat_counter
   import branch_predictor_pkg::*;
(
   input  logic [1:0] state,
   input  logic       taken,
   output logic [1:0] next_state
);
   always_comb begin
      next_state = state;
      if (taken) begin
         if (state != BHT_ST) next_state = state + 2'd1;
      end else begin
         if (state != BHT_SNT) next_state = state - 2'd1;
      end
   end
endmodule

// File: rtl/branch_predictor.sv
// Direction (2-bit BHT) + target (direct-mapped BTB) predictor for the fetch PC,
// trained by EX-stage resolution; raises flush/redirect on a mispredict and keeps
// branch / mispredict counters.
//   clk, rst : core clock, synchronous active-high reset
//   bp       : slave side of branch_predictor_if (lookup, EX feedback, redirect, stats)
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         IDX_W    = BP_IDX_WIDTH,
   parameter int         TAG_W    = BP_TAG_WIDTH,
   parameter logic [1:0] CNT_INIT = BHT_WNT
) (
   input  logic              clk,
   input  logic              rst,
   branch_predictor_if.slave bp
);
   localparam int ENTRIES = 1 << IDX_W;

   // Flop arrays: reset must clear every entry in a single cycle.
   logic [ENTRIES-1:0][1:0]       bht;
   logic [ENTRIES-1:0]            btb_valid;
   logic [ENTRIES-1:0][TAG_W-1:0] btb_tag;
   logic [ENTRIES-1:0][31:0]      btb_target;

   logic [31:0] stat_branches, stat_mispred;

   logic [IDX_W-1:0] look_idx, res_idx;
   logic [TAG_W-1:0] look_tag, res_tag;
   logic             look_hit, res, mispredict;
   logic [1:0]       bht_next;

   assign look_idx = bp.if_pc[IDX_W+1:2];
   assign look_tag = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign res_idx  = bp.old_pc[IDX_W+1:2];
   assign res_tag  = bp.old_pc[IDX_W+TAG_W+1:IDX_W+2];

   // Lookup reads the current (pre-update) arrays, so a same-cycle update to the
   // same index only becomes visible on the following cycle.
   assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

   always_comb begin
      bp.predict_taken = 1'b0;
      bp.predict_pc    = bp.if_pc + 32'd4;
      if (!rst && look_hit && bht[look_idx][1]) begin
         bp.predict_taken = 1'b1;
         bp.predict_pc    = btb_target[look_idx];
      end
   end

   // A predicted-taken branch that resolves taken can still be wrong if the
   // target moved (jalr), so the stored target is compared too.
   assign res        = bp.ex_valid && bp.old_branch && !rst;
   assign mispredict = res && ((bp.old_predict != bp.branch_result) ||
                               (bp.branch_result && bp.old_predict &&
                                (btb_target[res_idx] != bp.ex_target)));

   always_comb begin
      bp.flush       = mispredict;
      bp.redirect_pc = 32'd0;
      if (mispredict)
         bp.redirect_pc = bp.branch_result ? bp.ex_target : bp.old_pc + 32'd4;
   end

   branch_predictor_sat_counter u_sat (
      .state      (bht[res_idx]),
      .taken      (bp.branch_result),
      .next_state (bht_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ENTRIES; k++) begin
            bht[k]        <= CNT_INIT;
            btb_tag[k]    <= '0;
            btb_target[k] <= '0;
         end
         btb_valid     <= '0;
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else if (res) begin
         bht[res_idx] <= bht_next;
         if (bp.branch_result) begin
            btb_valid[res_idx]  <= 1'b1;
            btb_tag[res_idx]    <= res_tag;
            btb_target[res_idx] <= bp.ex_target;
         end
         stat_branches <= stat_branches + 32'd1;
         if (mispredict) stat_mispred <= stat_mispred + 32'd1;
      end
   end

   assign bp.stat_branches = stat_branches;
   assign bp.stat_mispred  = stat_mispred;

endmodule
